// File: rtl/lz77_decoder.sv
// lz77_decoder: byte-serial LZ77 decompressor for 2-byte tokens with a circular
// history window. Decoded bytes are counted per block; after BLOCK_LEN bytes the
// block finishes and the history is logically cleared via the fill count.
// Optional token checking is compiled in when LZ77_DEC_ERRCHK_EN is defined;
// otherwise err is tied low.
module lz77_decoder #(
   parameter int unsigned HIST_DEPTH = 1024,
   parameter int unsigned BLOCK_LEN  = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       i_rdy,
   input  logic       i_en,
   input  logic [7:0] i_data,
   input  logic       o_rdy,
   output logic       o_en,
   output logic [7:0] o_data,
   output logic       finish,
   output logic       err
);

   localparam int unsigned AW = $clog2(HIST_DEPTH);
   localparam int unsigned FW = AW + 1;
   localparam int unsigned CW = 13;
   localparam int unsigned IW = 11;
   localparam int unsigned LW = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ARG,
      S_EMIT,
      S_DONE
   } state_e;

   state_e        state_q, state_d;
   logic          i_rdy_q, i_rdy_d;
   logic          o_en_q, o_en_d;
   logic [7:0]    o_data_q, o_data_d;
   logic          finish_q, finish_d;
   logic [7:0]    b0_q, b0_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [LW-1:0] rem_q, rem_d;
   logic [AW-1:0] wp_q, wp_d;
   logic [FW-1:0] fill_q, fill_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [7:0]    mem [HIST_DEPTH];

   logic [4:0]    arg_len_c;
   logic [IW-1:0] arg_idx_c;
   logic [AW-1:0] rd_addr_c;
   logic [7:0]    rd_data_c;
   logic [FW-1:0] fill_inc_c;
   logic          wr_en_c;
   logic          in_xfer_c;

   assign arg_len_c  = b0_q[4:0];
   assign arg_idx_c  = {i_data, b0_q[7:5]};
   assign in_xfer_c  = i_en && i_rdy_q;
   assign fill_inc_c = (fill_q == FW'(HIST_DEPTH)) ? fill_q : fill_q + FW'(1);

   // History read port: ARG fetches the first copy byte, EMIT fetches the byte after the current push
   always_comb begin
      rd_addr_c = wp_q - AW'(1) - AW'(arg_idx_c);
      if (state_q == S_EMIT) begin
         rd_addr_c = wp_q - AW'(idx_q);
      end
      rd_data_c = mem[rd_addr_c];
   end

   // History RAM write: every accepted output byte is pushed at wp
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[wp_q] <= o_data_q;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      o_data_d = o_data_q;
      b0_d     = b0_q;
      idx_d    = idx_q;
      rem_d    = rem_q;
      wp_d     = wp_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      wr_en_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            fill_d = '0;
            wp_d   = '0;
            if (in_xfer_c) begin
               b0_d    = i_data;
               state_d = S_ARG;
            end
         end
         S_HDR: begin
            if (in_xfer_c) begin
               b0_d    = i_data;
               state_d = S_ARG;
            end
         end
         S_ARG: begin
            if (in_xfer_c) begin
               idx_d = arg_idx_c;
               rem_d = (arg_len_c == 5'd0) ? LW'(1) : LW'(arg_len_c);
               if (arg_len_c == 5'd0) begin
                  o_data_d = i_data;
               end else if (32'(arg_idx_c) >= 32'(fill_q)) begin
                  o_data_d = 8'h00;
               end else begin
                  o_data_d = rd_data_c;
               end
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            if (o_rdy) begin
               wr_en_c = 1'b1;
               wp_d    = wp_q + AW'(1);
               fill_d  = fill_inc_c;
               cnt_d   = cnt_q + CW'(1);
               rem_d   = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = ((32'(cnt_q) + 32'd1) >= BLOCK_LEN) ? S_DONE : S_HDR;
               end else if (32'(idx_q) >= 32'(fill_inc_c)) begin
                  o_data_d = 8'h00;
               end else if (idx_q == '0) begin
                  o_data_d = o_data_q;
               end else begin
                  o_data_d = rd_data_c;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      i_rdy_d  = (state_d == S_IDLE) || (state_d == S_HDR) || (state_d == S_ARG);
      o_en_d   = (state_d == S_EMIT);
      finish_d = (state_d == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         i_rdy_q  <= 1'b0;
         o_en_q   <= 1'b0;
         o_data_q <= 8'h00;
         finish_q <= 1'b0;
         b0_q     <= 8'h00;
         idx_q    <= '0;
         rem_q    <= '0;
         wp_q     <= '0;
         fill_q   <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         i_rdy_q  <= i_rdy_d;
         o_en_q   <= o_en_d;
         o_data_q <= o_data_d;
         finish_q <= finish_d;
         b0_q     <= b0_d;
         idx_q    <= idx_d;
         rem_q    <= rem_d;
         wp_q     <= wp_d;
         fill_q   <= fill_d;
         cnt_q    <= cnt_d;
      end
   end

   assign i_rdy  = i_rdy_q;
   assign o_en   = o_en_q;
   assign o_data = o_data_q;
   assign finish = finish_q;

`ifdef LZ77_DEC_ERRCHK_EN
   logic err_q, err_d;
   logic tok_bad_c;

   // Sticky malformed-token flag, raised as the token enters EMIT and cleared in IDLE
   always_comb begin
      tok_bad_c = 1'b0;
      if (arg_len_c == 5'd0) begin
         tok_bad_c = (b0_q != 8'h00);
      end else begin
         tok_bad_c = (arg_len_c > 5'd16) ||
                     (32'(arg_idx_c) >= 32'(fill_q)) ||
                     (32'(arg_idx_c) >= HIST_DEPTH);
      end
      err_d = err_q;
      if (state_q == S_IDLE) begin
         err_d = 1'b0;
      end else if ((state_q == S_ARG) && in_xfer_c && tok_bad_c) begin
         err_d = 1'b1;
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lz77_decoder.sv
// tb_lz77_decoder: randomized self-checking bench with a queue-based token model.
module tb_lz77_decoder;

   localparam int HIST = 1024;
   localparam int BLK  = 4096;
   localparam int TMO  = 400;

   typedef struct {
      logic [7:0] data;
      bit         fin;
      bit         err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_rdy;
   logic       i_en;
   logic [7:0] i_data;
   logic       o_rdy;
   logic       o_en;
   logic [7:0] o_data;
   logic       finish;
   logic       err;

   exp_t       expq[$];
   logic [7:0] hist[$];
   int         blk_cnt;
   int         blocks_done;
   bit         m_err;

   int         n_cmp;
   int         n_bad;

   int         gap_max;
   bit         rdy_rand;
   int         stall_skip;
   int         stall_n;
   bit         mon_en;

   exp_t       mon_e;
   bit         prev_stall;
   logic [7:0] prev_data;
   bit         exp_fin;

   lz77_decoder dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_rdy  (i_rdy),
      .i_en   (i_en),
      .i_data (i_data),
      .o_rdy  (o_rdy),
      .o_en   (o_en),
      .o_data (o_data),
      .finish (finish),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: history is the list of bytes decoded so far in this block
   task automatic model_token(input logic [7:0] b0, input logic [7:0] b1);
      int         len;
      int         idx;
      int         n;
      logic [7:0] d;
      exp_t       e;
      len = int'(b0[4:0]);
      idx = int'({b1, b0[7:5]});
`ifdef LZ77_DEC_ERRCHK_EN
      if (len == 0) begin
         if (b0 != 8'h00) m_err = 1'b1;
      end else if (len > 16 || idx >= hist.size() || idx >= HIST) begin
         m_err = 1'b1;
      end
`endif
      n = (len == 0) ? 1 : len;
      for (int k = 0; k < n; k++) begin
         if (len == 0) d = b1;
         else if (idx < hist.size()) d = hist[hist.size() - 1 - idx];
         else d = 8'h00;
         hist.push_back(d);
         if (hist.size() > HIST) void'(hist.pop_front());
         blk_cnt++;
         e.data = d;
         e.fin  = (k == n - 1) && (blk_cnt >= BLK);
         e.err  = m_err;
         expq.push_back(e);
      end
      if (blk_cnt >= BLK) begin
         hist.delete();
         blk_cnt = 0;
         m_err   = 1'b0;
         blocks_done++;
      end
   endtask

   // Offer one byte from a negedge; returns on the negedge after it was accepted
   task automatic send_byte(input logic [7:0] b);
      bit done;
      int g;
      done = 1'b0;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) @(negedge clk);
      i_en   = 1'b1;
      i_data = b;
      for (int t = 0; t < TMO && !done; t++) begin
         if (i_rdy) done = 1'b1;
         @(negedge clk);
      end
      i_en   = 1'b0;
      i_data = 8'($urandom);
      if (!done) chk("i_rdy_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_tok(input logic [7:0] b0, input logic [7:0] b1);
      model_token(b0, b1);
      send_byte(b0);
      send_byte(b1);
   endtask

   task automatic rand_tok();
      int         r;
      int         len;
      int         idx;
      logic [7:0] b0;
      logic [7:0] b1;
      r = int'($urandom_range(0, 19));
      if (r < 8) begin
         b0 = 8'h00;
         if (r == 0) b0 = {3'($urandom_range(1, 7)), 5'd0};
         b1 = 8'($urandom);
      end else begin
         len = (r == 19) ? int'($urandom_range(17, 31)) : int'($urandom_range(1, 16));
         if (r == 18 || hist.size() == 0) idx = int'($urandom_range(0, 2047));
         else if (r < 14) idx = int'($urandom_range(0, (hist.size() > 8) ? 7 : hist.size() - 1));
         else idx = int'($urandom_range(0, hist.size() - 1));
         b0 = {idx[2:0], len[4:0]};
         b1 = idx[10:3];
      end
      send_tok(b0, b1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (expq.size() != 0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      if (expq.size() != 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Output side: drive o_rdy, then check the beat that will transfer at the next posedge
   always @(negedge clk) begin
      if (o_en && stall_skip > 0) begin
         stall_skip--;
         o_rdy = 1'b1;
      end else if (o_en && stall_n > 0) begin
         stall_n--;
         o_rdy = 1'b0;
      end else if (rdy_rand) begin
         o_rdy = ($urandom_range(0, 3) != 0);
      end else begin
         o_rdy = 1'b1;
      end

      if (!mon_en || !rst_n) begin
         prev_stall = 1'b0;
         exp_fin    = 1'b0;
      end else begin
         chk("finish", 32'(finish), 32'(exp_fin));
         exp_fin = 1'b0;
         if (o_en) chk("i_rdy_in_emit", 32'(i_rdy), 32'd0);
         if (prev_stall) begin
            chk("hold_o_en", 32'(o_en), 32'd1);
            chk("hold_o_data", 32'(o_data), 32'(prev_data));
         end
         if (o_en && o_rdy) begin
            if (expq.size() == 0) begin
               chk("extra_beat", 32'd1, 32'd0);
            end else begin
               mon_e = expq.pop_front();
               chk("o_data", 32'(o_data), 32'(mon_e.data));
               chk("err", 32'(err), 32'(mon_e.err));
               exp_fin = mon_e.fin;
            end
         end
         prev_stall = o_en && !o_rdy;
         prev_data  = o_data;
      end
   end

   initial begin
      int t;
      n_cmp = 0; n_bad = 0;
      blk_cnt = 0; blocks_done = 0; m_err = 1'b0;
      gap_max = 0; rdy_rand = 1'b0; stall_skip = 0; stall_n = 0; mon_en = 1'b0;
      i_en = 1'b0; i_data = 8'h00; rst_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_i_rdy", 32'(i_rdy), 32'd0);
      chk("rst_o_en", 32'(o_en), 32'd0);
      chk("rst_o_data", 32'(o_data), 32'd0);
      chk("rst_finish", 32'(finish), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Block 1: reference before history, literals, overlap and distance copies
      send_tok(8'hA2, 8'h00);
      send_tok(8'h00, 8'h41);
      send_tok(8'h00, 8'h42);
      send_tok(8'h00, 8'h41);
      send_tok(8'h05, 8'h00);
      send_tok(8'h00, 8'h41);
      send_tok(8'h00, 8'h42);
      send_tok(8'h00, 8'h43);
      send_tok(8'h43, 8'h00);
      wait_drain();

      // Mid-copy backpressure on a len=4 copy
      stall_skip = 1;
      stall_n    = 3;
      send_tok(8'h64, 8'h00);
      wait_drain();
      chk("stall_consumed", 32'(stall_n), 32'd0);

      // Random tokens with input gaps and random o_rdy until the block completes
      rdy_rand = 1'b1;
      gap_max  = 2;
      while (blocks_done == 0) rand_tok();
      wait_drain();

      // Block 2: cleared history reads zero, then literals to the block end
      gap_max = 0;
      send_tok(8'h03, 8'h00);
      while (blocks_done == 1) send_tok(8'h00, 8'($urandom));
      wait_drain();

      // Block 3: reset in the middle of a long copy
      rdy_rand = 1'b0;
      send_tok(8'h02, 8'h00);
      send_tok(8'h00, 8'h55);
      send_tok(8'h10, 8'h00);
      t = 0;
      while (expq.size() > 10 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("pre_rst_o_en", 32'(o_en), 32'd1);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_o_en", 32'(o_en), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_i_rdy", 32'(i_rdy), 32'd0);
      chk("mid_rst_o_data", 32'(o_data), 32'd0);
      chk("mid_rst_finish", 32'(finish), 32'd0);
      expq.delete();
      hist.delete();
      blk_cnt = 0;
      m_err   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      send_tok(8'h00, 8'h77);
      send_tok(8'h01, 8'h00);
      send_tok(8'h20, 8'h00);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
